// File: rtl/dwc_recovery_ctrl_if.sv
// Handshake and status bundle between the dual-core comparator environment and
// the recovery controller; the controller attaches through the slave modport.
interface dwc_recovery_ctrl_if;
  logic        cmp_done;
  logic        cmp_match;
  logic        retry_ack;
  logic        irq_clr;
  logic        ack_a;
  logic        ack_b;
  logic        retry_req;
  logic        core_rst;
  logic        fault_irq;
  logic [15:0] pass_cnt;
  logic [15:0] err_cnt;
  logic [3:0]  retry_cnt;
  logic [2:0]  state;

  modport master (
    output cmp_done, cmp_match, retry_ack, irq_clr,
    input  ack_a, ack_b, retry_req, core_rst, fault_irq,
    input  pass_cnt, err_cnt, retry_cnt, state
  );

  modport slave (
    input  cmp_done, cmp_match, retry_ack, irq_clr,
    output ack_a, ack_b, retry_req, core_rst, fault_irq,
    output pass_cnt, err_cnt, retry_cnt, state
  );
endinterface

// File: rtl/dwc_recovery_ctrl.sv
// Dual-core lockstep recovery controller: acknowledges comparisons, requests
// retries on mismatch and escalates to a timed core reset with a sticky IRQ.
module dwc_recovery_ctrl #(
  parameter int MAX_RETRY     = 3,
  parameter int RETRY_TIMEOUT = 1024,
  parameter int RST_PULSE_CYC = 16
) (
  input logic                clk,
  input logic                reset,
  dwc_recovery_ctrl_if.slave bus
);

  localparam int WAIT_W  = (RETRY_TIMEOUT > 1) ? $clog2(RETRY_TIMEOUT) : 1;
  localparam int PULSE_W = (RST_PULSE_CYC > 1) ? $clog2(RST_PULSE_CYC) : 1;
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(RETRY_TIMEOUT - 1);
  localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(RST_PULSE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ACK        = 3'd1,
    S_RETRY_WAIT = 3'd2,
    S_CORE_RST   = 3'd3
  } state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [WAIT_W-1:0]   r_waitCnt;
  logic [PULSE_W-1:0]  r_pulseCnt;
  logic [15:0]         r_passCnt;
  logic [15:0]         r_errCnt;
  logic [3:0]          r_retryCnt;
  logic                r_faultIrq;
  logic                r_ackA;
  logic                r_ackB;
  logic                r_retryReq;
  logic                r_coreRst;

  logic                w_matchEvt;
  logic                w_mismatchEvt;
  logic [3:0]          w_retryInc;
  logic                w_ackNext;
  logic                w_retryReqNext;
  logic                w_coreRstNext;
  logic                w_enterRst;

  // cmp_match only matters while IDLE sees cmp_done; elsewhere it is ignored.
  assign w_matchEvt    = (r_state == S_IDLE) && bus.cmp_done && bus.cmp_match;
  assign w_mismatchEvt = (r_state == S_IDLE) && bus.cmp_done && !bus.cmp_match;
  assign w_retryInc    = (r_retryCnt == 4'hF) ? r_retryCnt : r_retryCnt + 4'd1;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_nextState;
  end

  // On a timeout edge a simultaneous retry_ack still wins and goes to ACK.
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_matchEvt)
          w_nextState = S_ACK;
        else if (w_mismatchEvt)
          w_nextState = (int'(w_retryInc) <= MAX_RETRY) ? S_RETRY_WAIT : S_CORE_RST;
      end
      S_RETRY_WAIT: begin
        if (bus.retry_ack)               w_nextState = S_ACK;
        else if (r_waitCnt == WAIT_LAST) w_nextState = S_CORE_RST;
      end
      S_CORE_RST: begin
        if (r_pulseCnt == PULSE_LAST) w_nextState = S_ACK;
      end
      S_ACK: begin
        if (!bus.cmp_done) w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  always_comb begin
    w_ackNext      = 1'b0;
    w_retryReqNext = 1'b0;
    w_coreRstNext  = 1'b0;
    unique case (w_nextState)
      S_ACK:        w_ackNext      = 1'b1;
      S_RETRY_WAIT: w_retryReqNext = 1'b1;
      S_CORE_RST:   w_coreRstNext  = 1'b1;
      default:      ;
    endcase
    w_enterRst = (w_nextState == S_CORE_RST) && (r_state != S_CORE_RST);
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ackA     <= 1'b0;
      r_ackB     <= 1'b0;
      r_retryReq <= 1'b0;
      r_coreRst  <= 1'b0;
      r_waitCnt  <= '0;
      r_pulseCnt <= '0;
      r_passCnt  <= '0;
      r_errCnt   <= '0;
      r_retryCnt <= '0;
      r_faultIrq <= 1'b0;
    end else begin
      r_ackA     <= w_ackNext;
      r_ackB     <= w_ackNext;
      r_retryReq <= w_retryReqNext;
      r_coreRst  <= w_coreRstNext;

      if (r_state == S_RETRY_WAIT && w_nextState == S_RETRY_WAIT)
        r_waitCnt <= r_waitCnt + WAIT_W'(1);
      else
        r_waitCnt <= '0;

      if (r_state == S_CORE_RST && w_nextState == S_CORE_RST)
        r_pulseCnt <= r_pulseCnt + PULSE_W'(1);
      else
        r_pulseCnt <= '0;

      if (w_matchEvt) begin
        if (r_passCnt != 16'hFFFF) r_passCnt <= r_passCnt + 16'd1;
        r_retryCnt <= '0;
      end
      if (w_mismatchEvt) begin
        if (r_errCnt != 16'hFFFF) r_errCnt <= r_errCnt + 16'd1;
        r_retryCnt <= w_retryInc;
      end
      // Escalation restarts the retry budget; it overrides the mismatch bump.
      if (w_enterRst) r_retryCnt <= '0;

      if (w_enterRst)       r_faultIrq <= 1'b1;
      else if (bus.irq_clr) r_faultIrq <= 1'b0;
    end
  end

  assign bus.ack_a     = r_ackA;
  assign bus.ack_b     = r_ackB;
  assign bus.retry_req = r_retryReq;
  assign bus.core_rst  = r_coreRst;
  assign bus.fault_irq = r_faultIrq;
  assign bus.pass_cnt  = r_passCnt;
  assign bus.err_cnt   = r_errCnt;
  assign bus.retry_cnt = r_retryCnt;
  assign bus.state     = r_state;

endmodule

// File: tb/tb_dwc_recovery_ctrl.sv
// Directed bench for dwc_recovery_ctrl: expected outputs are queued as each
// step is driven and popped against the DUT half a cycle after the edge.
module tb_dwc_recovery_ctrl;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ACK  = 3'd1;
  localparam logic [2:0] S_RW   = 3'd2;
  localparam logic [2:0] S_CRST = 3'd3;

  typedef struct packed {
    logic [2:0]  st;
    logic        ackA;
    logic        ackB;
    logic        rreq;
    logic        crst;
    logic        irq;
    logic [15:0] pass;
    logic [15:0] err;
    logic [3:0]  rcnt;
  } exp_t;

  logic        clk;
  logic        reset;
  int          checks   = 0;
  int          failures = 0;
  logic [15:0] mPass;
  logic [15:0] mErr;
  logic [3:0]  mRetry;
  logic        mIrq;
  exp_t        expQ[$];
  string       tagQ[$];

  dwc_recovery_ctrl_if bus();

  dwc_recovery_ctrl #(
    .MAX_RETRY    (3),
    .RETRY_TIMEOUT(1024),
    .RST_PULSE_CYC(16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired before the sequence completed");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic done, input logic match,
                               input logic rack, input logic clr);
    bus.cmp_done  = done;
    bus.cmp_match = match;
    bus.retry_ack = rack;
    bus.irq_clr   = clr;
  endtask

  task automatic pushExp(input string tag, input logic [2:0] st,
                         input logic act, input logic rreq, input logic crst);
    exp_t e;
    e.st   = st;
    e.ackA = act;
    e.ackB = act;
    e.rreq = rreq;
    e.crst = crst;
    e.irq  = mIrq;
    e.pass = mPass;
    e.err  = mErr;
    e.rcnt = mRetry;
    expQ.push_back(e);
    tagQ.push_back(tag);
  endtask

  task automatic cmp(input string tag, input string field,
                     input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s.%s observed=0x%0h expected=0x%0h", tag, field, obs, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t  e;
    string tag;
    if (expQ.size() == 0) begin
      checks++;
      failures++;
      $error("[TB] FAIL scoreboard observed=empty expected=entry");
      return;
    end
    e   = expQ.pop_front();
    tag = tagQ.pop_front();
    cmp(tag, "state",     {13'd0, bus.state},     {13'd0, e.st});
    cmp(tag, "ack_a",     {15'd0, bus.ack_a},     {15'd0, e.ackA});
    cmp(tag, "ack_b",     {15'd0, bus.ack_b},     {15'd0, e.ackB});
    cmp(tag, "retry_req", {15'd0, bus.retry_req}, {15'd0, e.rreq});
    cmp(tag, "core_rst",  {15'd0, bus.core_rst},  {15'd0, e.crst});
    cmp(tag, "fault_irq", {15'd0, bus.fault_irq}, {15'd0, e.irq});
    cmp(tag, "pass_cnt",  bus.pass_cnt,           e.pass);
    cmp(tag, "err_cnt",   bus.err_cnt,            e.err);
    cmp(tag, "retry_cnt", {12'd0, bus.retry_cnt}, {12'd0, e.rcnt});
  endtask

  task automatic observe(input string tag, input logic [2:0] st,
                         input logic act, input logic rreq, input logic crst);
    pushExp(tag, st, act, rreq, crst);
    checkOutput();
  endtask

  function automatic logic [15:0] sat16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic doMatch(input string tag);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    mPass  = sat16(mPass);
    mRetry = 4'd0;
    observe({tag, "_ack"}, S_ACK, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    observe({tag, "_idle"}, S_IDLE, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic doRetriedMismatch(input string tag);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    mErr   = sat16(mErr);
    mRetry = mRetry + 4'd1;
    observe({tag, "_rw"}, S_RW, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    observe({tag, "_ack"}, S_ACK, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    observe({tag, "_idle"}, S_IDLE, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic runCoreRstTail(input string tag);
    repeat (15) begin
      tick();
      observe({tag, "_hold"}, S_CRST, 1'b0, 1'b0, 1'b1);
    end
    tick();
    observe({tag, "_ack"}, S_ACK, 1'b1, 1'b0, 1'b0);
    tick();
    observe({tag, "_idle"}, S_IDLE, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    mPass  = 16'd0;
    mErr   = 16'd0;
    mRetry = 4'd0;
    mIrq   = 1'b0;
    reset  = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    observe("reset", S_IDLE, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    // Match, with cmp_done held for an extra cycle in ACK.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    mPass = 16'd1;
    observe("match_ack", S_ACK, 1'b1, 1'b0, 1'b0);
    tick();
    observe("match_hold", S_ACK, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    observe("match_idle", S_IDLE, 1'b0, 1'b0, 1'b0);

    // Single mismatch; retry_ack sampled at the end of the fifth RETRY_WAIT cycle.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    mErr   = 16'd1;
    mRetry = 4'd1;
    observe("retry_c1", S_RW, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (4) begin
      tick();
      observe("retry_wait", S_RW, 1'b0, 1'b1, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    observe("retry_ack", S_ACK, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    observe("retry_idle", S_IDLE, 1'b0, 1'b0, 1'b0);

    // Escalation on the fourth consecutive mismatch.
    doMatch("clr_retry");
    doRetriedMismatch("esc1");
    doRetriedMismatch("esc2");
    doRetriedMismatch("esc3");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    mErr   = sat16(mErr);
    mRetry = 4'd0;
    mIrq   = 1'b1;
    observe("esc4_crst", S_CRST, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    runCoreRstTail("esc4");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    mIrq = 1'b0;
    observe("irq_clr", S_IDLE, 1'b0, 1'b0, 1'b0);

    // Timeout with no retry_ack.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    mErr   = sat16(mErr);
    mRetry = 4'd1;
    observe("tmo_rw", S_RW, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (1023) tick();
    observe("tmo_last", S_RW, 1'b0, 1'b1, 1'b0);
    tick();
    mRetry = 4'd0;
    mIrq   = 1'b1;
    observe("tmo_crst", S_CRST, 1'b0, 1'b0, 1'b1);
    runCoreRstTail("tmo");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    mIrq = 1'b0;
    observe("tmo_irqclr", S_IDLE, 1'b0, 1'b0, 1'b0);

    // retry_ack on the timeout cycle itself wins.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    mErr   = sat16(mErr);
    mRetry = 4'd1;
    observe("tack_rw", S_RW, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (1023) tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    observe("tack_ack", S_ACK, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    observe("tack_idle", S_IDLE, 1'b0, 1'b0, 1'b0);

    // Saturation: preload the error counter, then keep mismatching.
    dut.r_errCnt = 16'hFFFF;
    mErr = 16'hFFFF;
    doRetriedMismatch("sat1");
    doRetriedMismatch("sat2");

    // irq_clr on the escalation edge: set wins, a later clear still works.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    mErr   = sat16(mErr);
    mRetry = 4'd0;
    mIrq   = 1'b1;
    observe("setwin_crst", S_CRST, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    mIrq = 1'b0;
    observe("crst_clr", S_CRST, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset during the eighth core_rst cycle.
    repeat (6) tick();
    observe("crst_c8", S_CRST, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    tick();
    mPass  = 16'd0;
    mErr   = 16'd0;
    mRetry = 4'd0;
    mIrq   = 1'b0;
    observe("mid_reset", S_IDLE, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    observe("post_reset", S_IDLE, 1'b0, 1'b0, 1'b0);
    doMatch("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dwc_recovery_ctrl.md
DWC_RECOVERY_CTRL -- requirements
Module: dwc_recovery_ctrl

Interface
REQ-001 Parameter: MAX_RETRY, default 3; mismatches tolerated per comparison before core reset escalation.
REQ-002 Parameter: RETRY_TIMEOUT, default 1024; cycles allowed for retry_ack before escalation.
REQ-003 Parameter: RST_PULSE_CYC, default 16; core_rst pulse length in cycles.
REQ-004 The block SHALL have port `clk`: input, 1 bit; clock, all logic on rising edge.
REQ-005 The block SHALL have port `reset`: input, 1 bit; synchronous, active-high reset.
REQ-006 The block SHALL have port `cmp_done`: input, 1 bit; comparator finished (bit 0 of comparator done word).
REQ-007 The block SHALL have port `cmp_match`: input, 1 bit; comparator result (bit 0 of isMatch word), valid while cmp_done=1.
REQ-008 The block SHALL have port `retry_ack`: input, 1 bit; both cores have restarted the compared work unit.
REQ-009 The block SHALL have port `irq_clr`: input, 1 bit; software clear of fault_irq.
REQ-010 The block SHALL have ports `ack_a` and `ack_b`: output, 1 bit each; acknowledge to comparator for core A and core B.
REQ-011 The block SHALL have port `retry_req`: output, 1 bit; request both cores to re-execute the last work unit.
REQ-012 The block SHALL have port `core_rst`: output, 1 bit; reset pulse to both processor cores.
REQ-013 The block SHALL have port `fault_irq`: output, 1 bit; sticky interrupt, escalation occurred.
REQ-014 The block SHALL have port `pass_cnt`: output, 16 bits; saturating count of matched comparisons.
REQ-015 The block SHALL have port `err_cnt`: output, 16 bits; saturating count of mismatched comparisons.
REQ-016 The block SHALL have port `retry_cnt`: output, 4 bits; mismatches on the current work unit.
REQ-017 The block SHALL have port `state`: output, 3 bits; encoding IDLE=0, ACK=1, RETRY_WAIT=2, CORE_RST=3.

Function
REQ-018 All outputs SHALL be registered and SHALL change only on the rising edge of clk.
REQ-019 In IDLE, when cmp_done=1 and cmp_match=1, the block SHALL increment pass_cnt, clear retry_cnt and enter ACK on the next edge.
REQ-020 In IDLE, when cmp_done=1 and cmp_match=0, the block SHALL increment err_cnt and retry_cnt.
REQ-021 On that mismatch, if the new retry_cnt <= MAX_RETRY, the block SHALL enter RETRY_WAIT; otherwise it SHALL enter CORE_RST.
REQ-022 In RETRY_WAIT, retry_req SHALL be 1 and a wait counter SHALL count from 0.
REQ-023 In RETRY_WAIT, retry_ack=1 SHALL cause entry to ACK.
REQ-024 In RETRY_WAIT, if the wait counter reaches RETRY_TIMEOUT-1 without retry_ack, the block SHALL enter CORE_RST; if retry_ack arrives on that same cycle, ACK SHALL win.
REQ-025 In CORE_RST, core_rst SHALL be 1 for exactly RST_PULSE_CYC cycles.
REQ-026 On entry to CORE_RST, the block SHALL set fault_irq and clear retry_cnt.
REQ-027 When the CORE_RST pulse ends, the block SHALL enter ACK.
REQ-028 In ACK, ack_a and ack_b SHALL both be 1 and held until cmp_done=0 is sampled, then the block SHALL return to IDLE with both acks low on that edge.
REQ-029 retry_req, core_rst, ack_a and ack_b SHALL be 0 in every state other than the one that drives them; they SHALL never be asserted together.
REQ-030 pass_cnt and err_cnt SHALL saturate at 0xFFFF with no wrap.
REQ-031 retry_cnt SHALL saturate at 15.
REQ-032 fault_irq SHALL be cleared by irq_clr=1; if set and clear occur in the same cycle, set SHALL win.
REQ-033 cmp_match SHALL be sampled only in IDLE with cmp_done=1; it SHALL be ignored in all other states.
REQ-034 cmp_done already high on return to IDLE SHALL be treated as a new comparison result.

Reset
REQ-035 While reset=1 on a clock edge, the block SHALL set state=IDLE and all outputs to 0, including counters, retry_cnt and fault_irq.
REQ-036 Reset asserted mid-operation (including during a core_rst pulse or RETRY_WAIT) SHALL deassert core_rst, retry_req and the acks on that edge and discard the pulse or timeout counters.

Verification
REQ-037 Match case: cmp_done=1, cmp_match=1 -> next edge state=ACK, ack_a=ack_b=1, pass_cnt=1; cmp_done=0 -> IDLE, acks 0.
REQ-038 Retry case: single mismatch, then retry_ack after 5 cycles -> retry_req high 5 cycles, err_cnt=1, retry_cnt=1, then ACK.
REQ-039 Escalation case: MAX_RETRY=3 with four consecutive mismatches, each retried -> fourth enters CORE_RST, core_rst high exactly 16 cycles, fault_irq=1, retry_cnt=0.
REQ-040 Timeout case: mismatch with no retry_ack -> CORE_RST entered after 1024 cycles in RETRY_WAIT; retry_ack on cycle 1024 -> ACK instead.
REQ-041 Saturation and irq case: preload err_cnt=0xFFFF then mismatch -> err_cnt stays 0xFFFF; irq_clr together with escalation -> fault_irq=1.
REQ-042 Reset case: reset at cycle 8 of core_rst -> next edge core_rst=0, state=IDLE, all counters 0.
